// File: rtl/dmem_line_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_line_responder
//  Description : Full-line memory responder for the M_DMEM port. Fixed read /
//                write latency, one-cycle done pulse, out-of-range flagging.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_line_responder #(
    parameter int XLEN        = 32,
    parameter int CBSIZE      = 256,
    parameter int DEPTH_LINES = 1024,
    parameter int RD_LATENCY  = 2,
    parameter int WR_LATENCY  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              S_DMEM_strobe_i,
    input  logic [XLEN-1:0]   S_DMEM_addr_i,
    input  logic              S_DMEM_rw_i,
    input  logic [CBSIZE-1:0] S_DMEM_data_i,
    output logic              S_DMEM_done_o,
    output logic [CBSIZE-1:0] S_DMEM_data_o,
    output logic              busy_o,
    output logic              addr_err_o
);

    localparam int         c_OFS     = $clog2(CBSIZE / 8);
    localparam int         c_IDXW    = $clog2(DEPTH_LINES);
    localparam int         c_LINEW   = XLEN - c_OFS;
    localparam logic [3:0] c_RD_LOAD = 4'(RD_LATENCY - 1);
    localparam logic [3:0] c_WR_LOAD = 4'(WR_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [c_LINEW-1:0]   line_q, line_d;
    logic                 rw_q, rw_d;
    logic [CBSIZE-1:0]    wdata_q, wdata_d;
    logic [CBSIZE-1:0]    rdata_q, rdata_d;

    logic [CBSIZE-1:0]    mem [DEPTH_LINES];

    logic [c_LINEW-1:0]   w_in_line;
    logic [c_LINEW-1:0]   w_rd_line;
    logic                 w_rd_oor;
    logic                 w_oor;
    logic [CBSIZE-1:0]    w_rd_value;
    logic                 unused_addr_ofs;

    assign w_in_line       = S_DMEM_addr_i[XLEN-1:c_OFS];
    assign unused_addr_ofs = ^S_DMEM_addr_i[c_OFS-1:0];

    // A one-cycle read enters DONE straight from IDLE, before the address is
    // latched, so the array lookup must use the live address in that case.
    assign w_rd_line  = (state_q == ST_IDLE) ? w_in_line : line_q;
    assign w_rd_oor   = (w_rd_line >= c_LINEW'(DEPTH_LINES));
    assign w_rd_value = w_rd_oor ? '0 : mem[w_rd_line[c_IDXW-1:0]];
    assign w_oor      = (line_q >= c_LINEW'(DEPTH_LINES));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (S_DMEM_strobe_i) begin
                    line_d  = w_in_line;
                    rw_d    = S_DMEM_rw_i;
                    wdata_d = S_DMEM_data_i;
                    cnt_d   = S_DMEM_rw_i ? c_WR_LOAD : c_RD_LOAD;
                    if (cnt_d == 4'd0) begin
                        state_d = ST_DONE;
                        if (!S_DMEM_rw_i) begin
                            rdata_d = w_rd_value;
                        end
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = ST_DONE;
                    if (!rw_q) begin
                        rdata_d = w_rd_value;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Commit on the edge leaving DONE; reset forces IDLE so an interrupted write is lost.
    always_ff @(posedge clk_i) begin
        if ((state_q == ST_DONE) && rw_q && !w_oor) begin
            mem[line_q[c_IDXW-1:0]] <= wdata_q;
        end
    end

    assign S_DMEM_done_o = (state_q == ST_DONE);
    assign busy_o        = (state_q != ST_IDLE);
    assign addr_err_o    = S_DMEM_done_o & w_oor;
    assign S_DMEM_data_o = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_line_responder
//  Description : Directed self-checking bench for dmem_line_responder.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_line_responder;

    logic         clk;
    logic         rst;
    logic         strobe, strobe_b, strobe_c;
    logic [31:0]  addr;
    logic         rw;
    logic [255:0] wdata;
    logic         done, done_b, done_c;
    logic         busy, busy_b, busy_c;
    logic         err, err_b, err_c;
    logic [255:0] dout, dout_b, dout_c;

    int tests = 0;
    int fails = 0;

    localparam logic [255:0] OLD5 = {8{32'h0BAD_0005}};
    localparam logic [255:0] NEW5 = {8{32'h600D_0005}};
    localparam logic [255:0] A5   = {8{32'hA5A5_A5A5}};
    localparam logic [255:0] AMO7 = {32'h0000_0007, {7{32'h1111_2222}}};
    localparam logic [255:0] AMO8 = {32'h0000_0008, {7{32'h1111_2222}}};
    localparam logic [255:0] Z0   = {8{32'h1234_5678}};
    localparam logic [255:0] P300 = {4{64'hFEED_FACE_0300_0300}};
    localparam logic [255:0] D1   = {8{32'hC0DE_0001}};
    localparam logic [255:0] D2   = {8{32'hC0DE_0002}};

    dmem_line_responder u_dut (
        .clk_i(clk), .rst_i(rst), .S_DMEM_strobe_i(strobe), .S_DMEM_addr_i(addr),
        .S_DMEM_rw_i(rw), .S_DMEM_data_i(wdata), .S_DMEM_done_o(done),
        .S_DMEM_data_o(dout), .busy_o(busy), .addr_err_o(err)
    );

    dmem_line_responder #(.RD_LATENCY(1), .WR_LATENCY(15)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .S_DMEM_strobe_i(strobe_b), .S_DMEM_addr_i(addr),
        .S_DMEM_rw_i(rw), .S_DMEM_data_i(wdata), .S_DMEM_done_o(done_b),
        .S_DMEM_data_o(dout_b), .busy_o(busy_b), .addr_err_o(err_b)
    );

    dmem_line_responder #(.RD_LATENCY(15), .WR_LATENCY(2)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .S_DMEM_strobe_i(strobe_c), .S_DMEM_addr_i(addr),
        .S_DMEM_rw_i(rw), .S_DMEM_data_i(wdata), .S_DMEM_done_o(done_c),
        .S_DMEM_data_o(dout_c), .busy_o(busy_c), .addr_err_o(err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction on the main instance; strobe drops after the accept edge.
    task automatic do_req(input logic r, input logic [31:0] a, input logic [255:0] d,
                          input bit churn, output int lat, output int busy_cnt,
                          output bit err_seen, output bit err_stray);
        rw = r; addr = a; wdata = d; strobe = 1'b1;
        lat = -1; busy_cnt = 0; err_seen = 1'b0; err_stray = 1'b0;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                strobe = 1'b0;
                if (churn) begin
                    addr = 32'h0000_0040; rw = ~r; wdata = ~d;
                end
            end
            if (busy) busy_cnt++;
            if (err && !done) err_stray = 1'b1;
            if (done) begin
                lat = n; err_seen = err;
            end
        end
        @(posedge clk); #1;
    endtask

    // One transaction on an auxiliary instance (1 = u_dut_b, 2 = u_dut_c).
    task automatic aux_req(input int which, input logic r, input logic [31:0] a,
                           input logic [255:0] d, output int lat, output int busy_cnt);
        rw = r; addr = a; wdata = d;
        if (which == 1) strobe_b = 1'b1; else strobe_c = 1'b1;
        lat = -1; busy_cnt = 0;
        for (int n = 1; n <= 25 && lat < 0; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                strobe_b = 1'b0; strobe_c = 1'b0;
            end
            if ((which == 1) ? busy_b : busy_c) busy_cnt++;
            if ((which == 1) ? done_b : done_c) lat = n;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        int lat, bc; bit es, st;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b expected 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", err); end
        tests++; if (dout !== 256'h0) begin fails++; $display("FAIL rst_data: got %h expected 0", dout); end
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(1'b1, 32'h0000_00A0, OLD5, 1'b0, lat, bc, es, st);
        rw = 1'b1; addr = 32'h0000_00A0; wdata = NEW5; strobe = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL rst_pre_done: got %b expected 1", done); end
        rst = 1'b1;
        #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done: got %b expected 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_req(1'b0, 32'h0000_00A0, '0, 1'b0, lat, bc, es, st);
        tests++; if (dout !== OLD5) begin fails++; $display("FAIL rst_no_commit: got %h expected %h", dout, OLD5); end
    endtask

    task automatic test_write_read();
        int lat, bc; bit es, st;
        do_req(1'b1, 32'h0000_0040, A5, 1'b0, lat, bc, es, st);
        tests++; if (lat !== 1) begin fails++; $display("FAIL wr_lat: got %0d expected 1", lat); end
        tests++; if (bc !== 1) begin fails++; $display("FAIL wr_busy: got %0d expected 1", bc); end
        tests++; if (dout !== OLD5) begin fails++; $display("FAIL wr_keeps_dout: got %h expected %h", dout, OLD5); end
        do_req(1'b0, 32'h0000_0054, '0, 1'b0, lat, bc, es, st);
        tests++; if (lat !== 2) begin fails++; $display("FAIL rd_lat: got %0d expected 2", lat); end
        tests++; if (bc !== 2) begin fails++; $display("FAIL rd_busy: got %0d expected 2", bc); end
        tests++; if (dout !== A5) begin fails++; $display("FAIL rd_data: got %h expected %h", dout, A5); end
        tests++; if (es !== 1'b0) begin fails++; $display("FAIL rd_err: got %b expected 0", es); end
    endtask

    task automatic test_amo();
        int lat, bc, k; bit es, st;
        do_req(1'b1, 32'h0000_0100, AMO7, 1'b0, lat, bc, es, st);
        rw = 1'b0; addr = 32'h0000_0100; strobe = 1'b1; k = -1;
        for (int n = 1; n <= 10 && k < 0; n++) begin
            @(posedge clk); #1;
            if (done) k = n;
        end
        tests++; if (k !== 2) begin fails++; $display("FAIL amo_rd_lat: got %0d expected 2", k); end
        tests++; if (dout[255:224] !== 32'h7) begin fails++; $display("FAIL amo_rd_word: got %h expected 7", dout[255:224]); end
        rw = 1'b1; wdata = AMO8;
        @(posedge clk); #1;
        tests++; if ({done, busy} !== 2'b00) begin fails++; $display("FAIL amo_gap: got done/busy %b expected 00", {done, busy}); end
        @(posedge clk); #1;
        strobe = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL amo_wr_done: got %b expected 1", done); end
        @(posedge clk); #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL amo_single_pulse: got %b expected 0", done); end
        do_req(1'b0, 32'h0000_0100, '0, 1'b0, lat, bc, es, st);
        tests++; if (dout[255:224] !== 32'h8) begin fails++; $display("FAIL amo_final: got %h expected 8", dout[255:224]); end
    endtask

    task automatic test_out_of_range();
        int lat, bc; bit es, st;
        do_req(1'b1, 32'h0000_0000, Z0, 1'b0, lat, bc, es, st);
        do_req(1'b0, 32'h0000_8000, '0, 1'b0, lat, bc, es, st);
        tests++; if (lat !== 2) begin fails++; $display("FAIL oor_rd_lat: got %0d expected 2", lat); end
        tests++; if (es !== 1'b1) begin fails++; $display("FAIL oor_rd_err: got %b expected 1", es); end
        tests++; if (st !== 1'b0) begin fails++; $display("FAIL oor_err_stray: got %b expected 0", st); end
        tests++; if (dout !== 256'h0) begin fails++; $display("FAIL oor_rd_data: got %h expected 0", dout); end
        do_req(1'b1, 32'h0000_8000, ~Z0, 1'b0, lat, bc, es, st);
        tests++; if (lat !== 1) begin fails++; $display("FAIL oor_wr_lat: got %0d expected 1", lat); end
        tests++; if (es !== 1'b1) begin fails++; $display("FAIL oor_wr_err: got %b expected 1", es); end
        do_req(1'b0, 32'h0000_0000, '0, 1'b0, lat, bc, es, st);
        tests++; if (dout !== Z0) begin fails++; $display("FAIL oor_wr_dropped: got %h expected %h", dout, Z0); end
        tests++; if (es !== 1'b0) begin fails++; $display("FAIL inrange_err: got %b expected 0", es); end
    endtask

    task automatic test_input_churn();
        int lat, bc; bit es, st;
        do_req(1'b1, 32'h0000_0300, P300, 1'b0, lat, bc, es, st);
        do_req(1'b0, 32'h0000_0300, '0, 1'b1, lat, bc, es, st);
        tests++; if (lat !== 2) begin fails++; $display("FAIL churn_lat: got %0d expected 2", lat); end
        tests++; if (dout !== P300) begin fails++; $display("FAIL churn_data: got %h expected %h", dout, P300); end
        do_req(1'b0, 32'h0000_0040, '0, 1'b0, lat, bc, es, st);
        tests++; if (dout !== A5) begin fails++; $display("FAIL churn_no_write: got %h expected %h", dout, A5); end
    endtask

    task automatic test_latency_sweep();
        int lat, bc;
        aux_req(1, 1'b1, 32'h0000_0020, D1, lat, bc);
        tests++; if (lat !== 15) begin fails++; $display("FAIL b_wr_lat: got %0d expected 15", lat); end
        tests++; if (bc !== 15) begin fails++; $display("FAIL b_wr_busy: got %0d expected 15", bc); end
        aux_req(1, 1'b0, 32'h0000_0020, '0, lat, bc);
        tests++; if (lat !== 1) begin fails++; $display("FAIL b_rd_lat: got %0d expected 1", lat); end
        tests++; if (bc !== 1) begin fails++; $display("FAIL b_rd_busy: got %0d expected 1", bc); end
        tests++; if (dout_b !== D1) begin fails++; $display("FAIL b_rd_data: got %h expected %h", dout_b, D1); end
        aux_req(2, 1'b1, 32'h0000_0020, D2, lat, bc);
        tests++; if (lat !== 2) begin fails++; $display("FAIL c_wr_lat: got %0d expected 2", lat); end
        tests++; if (bc !== 2) begin fails++; $display("FAIL c_wr_busy: got %0d expected 2", bc); end
        aux_req(2, 1'b0, 32'h0000_0020, '0, lat, bc);
        tests++; if (lat !== 15) begin fails++; $display("FAIL c_rd_lat: got %0d expected 15", lat); end
        tests++; if (bc !== 15) begin fails++; $display("FAIL c_rd_busy: got %0d expected 15", bc); end
        tests++; if (dout_c !== D2) begin fails++; $display("FAIL c_rd_data: got %h expected %h", dout_c, D2); end
    endtask

    initial begin
        rst = 1'b1; strobe = 1'b0; strobe_b = 1'b0; strobe_c = 1'b0;
        addr = '0; rw = 1'b0; wdata = '0;
        test_reset();
        test_write_read();
        test_amo();
        test_out_of_range();
        test_input_churn();
        test_latency_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
